// File: rtl/oclib_pkg.sv
// Shared UART transmit types and helpers for the oclib UART blocks.
package oclib_pkg;

   typedef enum logic [1:0] {
      UartTxIdle,
      UartTxStart,
      UartTxData,
      UartTxStop
   } uart_tx_state_e;

   function automatic int UartCyclesPerBit(input int clock_hz, input int baud);
      return clock_hz / baud;
   endfunction

endpackage

// File: rtl/oclib_uart_tx_arbiter_if.sv
// Requester-side byte streams plus the shared UART line and status of the TX arbiter.
interface oclib_uart_tx_arbiter_if #(
   parameter int Requesters = 4
) ();
   localparam int GrantW = (Requesters > 1) ? $clog2(Requesters) : 1;

   logic [Requesters*8-1:0] inData;
   logic [Requesters-1:0]   inValid;
   logic [Requesters-1:0]   inLast;
   logic [Requesters-1:0]   inReady;
   logic                    tx;
   logic                    busy;
   logic [GrantW-1:0]       grantId;

   modport master (
      output inData, inValid, inLast,
      input  inReady, tx, busy, grantId
   );

   modport slave (
      input  inData, inValid, inLast,
      output inReady, tx, busy, grantId
   );
endinterface

// File: rtl/oclib_uart_tx_serializer.sv
// 8N1 serializer: byte accepted in one cycle, start bit on the next; ready while idle or in the
// last stop-bit cycle so back-to-back frames leave no idle gap.
module oclib_uart_tx_serializer
   import oclib_pkg::*;
#(
   parameter int ClockHz = 100000000,
   parameter int Baud    = 115200
) (
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       idle_o
);
   localparam int Cpb   = UartCyclesPerBit(ClockHz, Baud);
   localparam int BaudW = (Cpb > 1) ? $clog2(Cpb) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(Cpb - 1);

   if (Cpb < 4) begin : g_bad_rate
      $error("oclib_uart_tx_serializer: ClockHz/Baud must be at least 4");
   end

   uart_tx_state_e   state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             baud_end;

   assign baud_end = (baud_q == BaudLast);
   assign ready_o  = (state_q == UartTxIdle) || ((state_q == UartTxStop) && baud_end);
   assign idle_o   = (state_q == UartTxIdle);
   assign tx_o     = (state_q == UartTxStart) ? 1'b0 :
                     (state_q == UartTxData)  ? shreg_q[0] : 1'b1;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= UartTxIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   // Baud counter wraps at terminal count in every active state, so bit edges never drift.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_end ? '0 : baud_q + BaudW'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      unique case (state_q)
         UartTxIdle: begin
            baud_d = '0;
            if (valid_i) begin
               state_d = UartTxStart;
               shreg_d = data_i;
            end
         end
         UartTxStart: begin
            if (baud_end) begin
               state_d = UartTxData;
               bit_d   = '0;
            end
         end
         UartTxData: begin
            if (baud_end) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_q == 3'd7) state_d = UartTxStop;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         UartTxStop: begin
            if (baud_end) begin
               if (valid_i) begin
                  state_d = UartTxStart;
                  shreg_d = data_i;
               end else begin
                  state_d = UartTxIdle;
               end
            end
         end
         default: state_d = UartTxIdle;
      endcase
   end

endmodule

// File: rtl/oclib_uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART TX line; inReady is combinational from inValid
// and only offered while the serializer can take a byte. A stalled owner loses the lock on timeout.
module oclib_uart_tx_arbiter
   import oclib_pkg::*;
#(
   parameter int ClockHz         = 100000000,
   parameter int Baud            = 115200,
   parameter int Requesters      = 4,
   parameter int LockTimeoutBits = 64
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   oclib_uart_tx_arbiter_if.slave  arb_if
);
   localparam int GrantW        = (Requesters > 1) ? $clog2(Requesters) : 1;
   localparam int Cpb           = UartCyclesPerBit(ClockHz, Baud);
   localparam int TimeoutCycles = LockTimeoutBits * Cpb;
   localparam int TimerW        = $clog2(TimeoutCycles + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

   if (Requesters < 1 || Requesters > 16) begin : g_bad_req
      $error("oclib_uart_tx_arbiter: Requesters must be 1..16");
   end
   if (LockTimeoutBits < 1) begin : g_bad_timeout
      $error("oclib_uart_tx_arbiter: LockTimeoutBits must be at least 1");
   end

   logic                  lock_q, lock_d;
   logic [GrantW-1:0]     owner_q, owner_d;
   logic [GrantW-1:0]     last_q, last_d;
   logic [GrantW-1:0]     grant_q, grant_d;
   logic [TimerW-1:0]     timer_q, timer_d;

   logic                  rr_vld;
   logic [GrantW-1:0]     rr_idx;
   logic                  win_vld, win_last, accept;
   logic [GrantW-1:0]     win_idx;
   logic [7:0]            win_data;
   logic [Requesters-1:0] ready_vec;
   logic                  ser_rdy, ser_idle;

   // Scan from the highest offset down so the first valid after last_q wins; last_q itself is lowest.
   always_comb begin
      int idx;
      rr_vld = 1'b0;
      rr_idx = '0;
      for (int k = Requesters; k >= 1; k--) begin
         idx = (int'(last_q) + k) % Requesters;
         if (arb_if.inValid[idx]) begin
            rr_vld = 1'b1;
            rr_idx = GrantW'(idx);
         end
      end
   end

   assign win_idx  = lock_q ? owner_q : rr_idx;
   assign win_vld  = lock_q ? arb_if.inValid[owner_q] : rr_vld;
   assign win_last = arb_if.inLast[win_idx];
   assign win_data = arb_if.inData[int'(win_idx)*8 +: 8];
   assign accept   = win_vld & ser_rdy;

   always_comb begin
      ready_vec = '0;
      if (accept) ready_vec[win_idx] = 1'b1;
   end

   oclib_uart_tx_serializer #(
      .ClockHz (ClockHz),
      .Baud    (Baud)
   ) u_ser (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .data_i    (win_data),
      .valid_i   (win_vld),
      .ready_o   (ser_rdy),
      .tx_o      (arb_if.tx),
      .idle_o    (ser_idle)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lock_q  <= 1'b0;
         owner_q <= '0;
         last_q  <= '0;
         grant_q <= '0;
         timer_q <= '0;
      end else begin
         lock_q  <= lock_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         timer_q <= timer_d;
      end
   end

   // The timeout only runs while the line is idle and the owner has nothing to offer.
   always_comb begin
      lock_d  = lock_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      timer_d = timer_q;
      if (accept) begin
         grant_d = win_idx;
         timer_d = '0;
         if (win_last) begin
            lock_d = 1'b0;
            last_d = win_idx;
         end else begin
            lock_d  = 1'b1;
            owner_d = win_idx;
         end
      end else if (lock_q && ser_idle && !arb_if.inValid[owner_q]) begin
         if (timer_q == TimerLast) begin
            lock_d  = 1'b0;
            last_d  = owner_q;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TimerW'(1);
         end
      end
   end

   assign arb_if.inReady = ready_vec;
   assign arb_if.busy    = ~ser_idle | lock_q;
   assign arb_if.grantId = grant_q;

endmodule

// File: tb/tb_oclib_uart_tx_arbiter.sv
// Directed bench for oclib_uart_tx_arbiter at 16 cycles/bit, 4 requesters, 4 bit-time lock timeout.
module tb_oclib_uart_tx_arbiter;
   localparam int Req      = 4;
   localparam int Cpb      = 16;
   localparam int FrameCyc = 10 * Cpb;
   localparam int WaitMax  = 600;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   oclib_uart_tx_arbiter_if #(.Requesters(Req)) arb_if ();

   oclib_uart_tx_arbiter #(
      .ClockHz         (1600000),
      .Baud            (100000),
      .Requesters      (Req),
      .LockTimeoutBits (4)
   ) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .arb_if    (arb_if)
   );

   // Line receiver: samples mid-bit, drops any frame cut by reset, counts bad stop bits.
   logic [7:0] rx_q[$];
   int         rx_ferr = 0;
   bit         rx_act  = 1'b0;
   int         rx_cnt  = 0;
   logic [7:0] rx_sh   = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_act <= 1'b0;
      end else if (!rx_act) begin
         if (arb_if.tx == 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 1;
         end
      end else begin
         if (rx_cnt % Cpb == Cpb / 2 && rx_cnt > Cpb) begin
            if (rx_cnt < 9 * Cpb) begin
               rx_sh <= {arb_if.tx, rx_sh[7:1]};
            end else begin
               if (arb_if.tx !== 1'b1) rx_ferr <= rx_ferr + 1;
               else                    rx_q.push_back(rx_sh);
               rx_act <= 1'b0;
            end
         end
         rx_cnt <= rx_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] d, input logic l, input logic v);
      arb_if.inData[i*8 +: 8] = d;
      arb_if.inLast[i]        = l;
      arb_if.inValid[i]       = v;
   endtask

   task automatic wait_rdy(output int cyc);
      cyc = 0;
      while (arb_if.inReady == '0 && cyc < WaitMax) begin
         tick();
         cyc++;
      end
   endtask

   task automatic get_rx(output logic [7:0] b);
      if (rx_q.size() > 0) b = rx_q.pop_front();
      else                 b = 8'hxx;
   endtask

   function automatic logic fbit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   initial begin
      int         cyc;
      logic [7:0] b;
      logic [7:0] exp_b;

      arb_if.inData  = '0;
      arb_if.inValid = '0;
      arb_if.inLast  = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx",    arb_if.tx,      1);
      chk("rst_ready", arb_if.inReady, 0);
      chk("rst_busy",  arb_if.busy,    0);
      chk("rst_gid",   arb_if.grantId, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("idle_tx", arb_if.tx, 1);

      // Single byte 0x55 from req 2.
      set_req(2, 8'h55, 1'b1, 1'b1);
      #1 chk("t1_ready", arb_if.inReady, 4'b0100);
      tick();
      set_req(2, 8'h55, 1'b1, 1'b0);
      #1;
      chk("t1_gid",  arb_if.grantId, 2);
      chk("t1_busy", arb_if.busy,    1);
      for (int c = 1; c <= FrameCyc; c++) begin
         if ((c - 1) % Cpb == 0 || (c - 1) % Cpb == Cpb - 1)
            chk($sformatf("t1_bit%0d_c%0d", (c - 1) / Cpb, c), arb_if.tx, fbit(8'h55, (c - 1) / Cpb));
         if (c == FrameCyc) chk("t1_busy_last", arb_if.busy, 1);
         tick();
      end
      chk("t1_busy_off", arb_if.busy, 0);
      chk("t1_tx_idle",  arb_if.tx,   1);
      get_rx(b);
      chk("t1_rx", b, 8'h55);

      // Req 0 sends "AB" under lock while req 1 waits with 0x31.
      set_req(0, 8'h41, 1'b0, 1'b1);
      set_req(1, 8'h31, 1'b1, 1'b1);
      #1 chk("t2_ready_a", arb_if.inReady, 4'b0001);
      tick();
      set_req(0, 8'h42, 1'b1, 1'b1);
      #1;
      chk("t2_ready_busy", arb_if.inReady, 0);
      chk("t2_gid_a",      arb_if.grantId, 0);
      wait_rdy(cyc);
      chk("t2_wait_b",  cyc,            FrameCyc - 1);
      chk("t2_ready_b", arb_if.inReady, 4'b0001);
      tick();
      set_req(0, 8'h42, 1'b1, 1'b0);
      #1 chk("t2_ready_mid", arb_if.inReady, 0);
      wait_rdy(cyc);
      chk("t2_wait_c",  cyc,            FrameCyc - 1);
      chk("t2_ready_c", arb_if.inReady, 4'b0010);
      tick();
      set_req(1, 8'h31, 1'b1, 1'b0);
      #1 chk("t2_gid_c", arb_if.grantId, 1);
      repeat (FrameCyc) tick();
      get_rx(b); chk("t2_rx0", b, 8'h41);
      get_rx(b); chk("t2_rx1", b, 8'h42);
      get_rx(b); chk("t2_rx2", b, 8'h31);

      // Req 3 locks with 0x7E then stalls; req 0 gets the line after the timeout.
      set_req(3, 8'h7E, 1'b0, 1'b1);
      set_req(0, 8'h21, 1'b1, 1'b1);
      #1 chk("t4_ready_lock", arb_if.inReady, 4'b1000);
      tick();
      set_req(3, 8'h7E, 1'b0, 1'b0);
      #1;
      chk("t4_gid",        arb_if.grantId, 3);
      chk("t4_ready_busy", arb_if.inReady, 0);
      repeat (170) tick();
      chk("t4_busy_locked",  arb_if.busy,    1);
      chk("t4_ready_locked", arb_if.inReady, 0);
      wait_rdy(cyc);
      chk("t4_wait_release", cyc,            54);
      chk("t4_ready_rel",    arb_if.inReady, 4'b0001);
      chk("t4_busy_rel",     arb_if.busy,    0);
      tick();
      set_req(0, 8'h21, 1'b1, 1'b0);
      set_req(3, 8'h0A, 1'b1, 1'b1);
      #1;
      chk("t4_gid_21",   arb_if.grantId, 0);
      chk("t4_ready_21", arb_if.inReady, 0);
      wait_rdy(cyc);
      chk("t4_wait_3",  cyc,            FrameCyc - 1);
      chk("t4_ready_3", arb_if.inReady, 4'b1000);
      tick();
      set_req(3, 8'h0A, 1'b1, 1'b0);
      #1 chk("t4_gid_3", arb_if.grantId, 3);
      repeat (FrameCyc) tick();
      get_rx(b); chk("t4_rx0", b, 8'h7E);
      get_rx(b); chk("t4_rx1", b, 8'h21);
      get_rx(b); chk("t4_rx2", b, 8'h0A);

      // All four valid with one-byte messages, two rounds.
      for (int i = 0; i < Req; i++) set_req(i, 8'(8'h30 + i), 1'b1, 1'b1);
      #1;
      for (int k = 0; k < 2 * Req; k++) begin
         wait_rdy(cyc);
         chk($sformatf("t3_wait%0d", k),  cyc,            (k == 0) ? 0 : FrameCyc - 1);
         chk($sformatf("t3_ready%0d", k), arb_if.inReady, 32'(1) << (k % Req));
         tick();
         chk($sformatf("t3_gid%0d", k),   arb_if.grantId, k % Req);
      end
      for (int i = 0; i < Req; i++) set_req(i, 8'(8'h30 + i), 1'b1, 1'b0);
      repeat (FrameCyc) tick();
      for (int k = 0; k < 2 * Req; k++) begin
         get_rx(b);
         exp_b = 8'(8'h30 + (k % Req));
         chk($sformatf("t3_rx%0d", k), b, exp_b);
      end

      // Reset 40 cycles into a 0xA5 frame, then a clean 0x5A from req 1.
      set_req(2, 8'hA5, 1'b1, 1'b1);
      #1 chk("t5_ready_a5", arb_if.inReady, 4'b0100);
      tick();
      set_req(2, 8'hA5, 1'b1, 1'b0);
      repeat (39) tick();
      chk("t5_pre_tx", arb_if.tx, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_tx",   arb_if.tx,      1);
      chk("t5_rst_busy", arb_if.busy,    0);
      chk("t5_rst_gid",  arb_if.grantId, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      set_req(1, 8'h5A, 1'b1, 1'b1);
      #1 chk("t5_ready_5a", arb_if.inReady, 4'b0010);
      tick();
      set_req(1, 8'h5A, 1'b1, 1'b0);
      #1 chk("t5_gid", arb_if.grantId, 1);
      repeat (FrameCyc) tick();
      chk("t5_rx_count", rx_q.size(), 1);
      get_rx(b);
      chk("t5_rx", b, 8'h5A);
      chk("stop_bit_errors", rx_ferr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/oclib_uart_tx_arbiter.md
Name: oclib_uart_tx_arbiter

Overview:
Shares one 8N1 UART transmit line between N byte-stream requesters.
- Each requester presents bytes with a `last` marker.
- A round-robin arbiter grants one requester and holds that grant (message lock) until its `last` byte is accepted or a lock timeout expires.
- An embedded serializer drives the line. The block sits between on-chip debug/console sources and the board UART pin, which a `Baud`-matched sim UART model observes.

Parameters:
- ClockHz, 100000000, clock frequency in Hz.
- Baud, 115200, line rate. CyclesPerBit = ClockHz/Baud (integer divide, must be >= 4; elaboration error otherwise).
- Requesters, 4, number of sources (1..16).
- LockTimeoutBits, 64, bit-times a locked owner may sit with inValid low before the lock is forcibly released.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- inData  in  Requesters*8  byte per requester; requester i at [i*8+:8].
- inValid  in  Requesters  per-requester byte valid.
- inLast  in  Requesters  byte is the final byte of the message.
- inReady  out  Requesters  one-hot or zero; byte accepted when inValid[i]&inReady[i].
- tx  out  1  UART line, idle high.
- busy  out  1  serializer active or lock held.
- grantId  out  $clog2(Requesters) (min 1)  current/last owner.

Behaviour:
- Reset (reset low, async): tx=1, inReady=0, busy=0, grantId=0, lock clear, RR pointer=0, serializer IDLE. Reset mid-frame drops tx to 1 immediately; the partial byte is lost and never retried.
- Serializer states: IDLE -> START -> DATA -> STOP -> IDLE.
  - Accept at cycle T: tx=0 from T+1 for CyclesPerBit cycles.
  - Data LSB first, each bit CyclesPerBit cycles.
  - Stop bit high for CyclesPerBit cycles.
  - Frame occupies cycles T+1 .. T+10*CyclesPerBit. Back-to-back: next accept at earliest cycle T+10*CyclesPerBit, so its start bit begins with no idle gap.
- inReady is asserted only while the serializer is IDLE (or in the final stop cycle, for back-to-back), and only to:
  - the lock owner, if the lock is held;
  - otherwise the RR winner among inValid: search from (lastGrant+1) mod Requesters upward with wrap. inReady for the winner is combinational from inValid in the same cycle.
- Accept with inLast=0: lock set, owner=granted index, grantId updated. Accept with inLast=1: lock cleared after the accept; lastGrant=index. A one-byte message is a single accept with inLast=1.
- While locked, other requesters are never granted, even if the owner has inValid low.
- Lock timeout:
  - Counter counts cycles with lock held, serializer IDLE and owner inValid low. It clears on any owner accept.
  - At LockTimeoutBits*CyclesPerBit cycles, the lock clears and the pointer advances past the owner.
- busy = (serializer != IDLE) | lock.
- Simultaneous inValid from several requesters: exactly one inReady bit is set. An owner deasserting inValid is legal and inData changes are ignored until the next accept. The block places no protocol assumption on inData stability without inValid.
- Bit counter is 3 bits. The baud counter width is $clog2(CyclesPerBit) and it reloads at terminal count, with no drift across frames.

Decomposition:
- oclib_pkg gets a typedef enum for serializer states (UartTxIdle, UartTxStart, UartTxData, UartTxStop) and a function UartCyclesPerBit(ClockHz, Baud).
- One sub-module, oclib_uart_tx_serializer: byte/valid/ready in, tx out, Baud/ClockHz parameters.
- The arbiter, lock and timeout live in the top.

Test Plan (ClockHz=1600000, Baud=100000 -> 16 cycles/bit, Requesters=4, LockTimeoutBits=4; bench ocsim_uart at Baud=100000 with Expect/WaitForIdle):
- Single byte 0x55 from req 2 with inLast=1 -> accept in 1 cycle; tx low at T+1; line 0,1,0,1,0,1,0,1,0,1 over 160 cycles; model receives 0x55; grantId=2; busy falls at T+160.
- Req 0 sends "AB" (0x41 inLast=0, 0x42 inLast=1) while req 1 holds 0x31 valid -> line carries 0x41,0x42,0x31 in order; inReady[1] stays 0 until after 0x42 is accepted.
- All 4 valid with single-byte messages 0x30+i, repeated twice -> grant order 0,1,2,3,0,1,2,3; no starvation.
- Req 3 sends 0x7E inLast=0 then stalls; req 0 is valid with 0x21 -> lock releases 64 cycles after the stop bit ends; 0x21 is sent next; req 3 re-arbitrates later.
- Reset pulse 40 cycles into a 0xA5 frame -> tx=1 within the same cycle; after release, 0x5A from req 1 transmits cleanly; the model sees only 0x5A (the partial frame is flagged by the model's stop-bit assert and is excluded by the bench).
